// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with atomic snapshot and indexed shadow readout
// Optional read-and-clear snapshot when PERF_CNT_SNAP_CLR_EN is defined.
module perf_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic                    snap,
  input  logic                    rd_req,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_ovf,
  output logic                    rd_valid,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH*WIDTH-1:0] counts
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [WIDTH-1:0]  shd_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] shd_ovf_q;

  logic              sel_ok;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_ovf;

  logic              rd_pend_q;
  logic [WIDTH-1:0]  rd_pend_data_q;
  logic              rd_pend_ovf_q;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_ovf_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
`ifdef PERF_CNT_SNAP_CLR_EN
      end else if (snap) begin
        // The event arriving with the snapshot starts the next interval.
        cnt_d[i] = {{(WIDTH-1){1'b0}}, enable[i]};
        ovf_d[i] = 1'b0;
`endif
      end else if (enable[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
      ovf_q     <= '0;
      shd_ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
      if (snap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          shd_q[i] <= cnt_q[i];
        end
        shd_ovf_q <= ovf_q;
      end
    end
  end

  assign sel_ok = (32'(rd_sel) < NUM_CH);

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    if (sel_ok) begin
      sel_data = shd_q[rd_sel];
      sel_ovf  = shd_ovf_q[rd_sel];
    end
  end

  // Request stage samples pre-snap shadows; the result is issued one edge later so a reset there drops it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pend_q      <= 1'b0;
      rd_pend_data_q <= '0;
      rd_pend_ovf_q  <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_ovf_q       <= 1'b0;
    end else begin
      rd_pend_q  <= rd_req;
      rd_valid_q <= rd_pend_q;
      if (rd_req) begin
        rd_pend_data_q <= sel_data;
        rd_pend_ovf_q  <= sel_ovf;
      end
      if (rd_pend_q) begin
        rd_data_q <= rd_pend_data_q;
        rd_ovf_q  <= rd_pend_ovf_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign counts[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign overflow = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;

endmodule
